// File: rtl/gfx_pkg.sv
// Shared write-FSM encoding and AXI constants for the
// pixel-to-AXI writer.
package gfx_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_XFER = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [3:0] STRB_ALL   = 4'hF;

    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/gfx_pixel_axi_writer_if.sv
// Single-beat AXI4 write channels (AW, W, B) driven by the
// pixel writer.
interface gfx_pixel_axi_writer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awvalid, awlen, awsize, awburst,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, awlen, awsize, awburst,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/gfx_pixel_fifo.sv
// Synchronous pixel buffer; extra pointer bit tells full
// from empty.
module gfx_pixel_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/gfx_pixel_axi_writer.sv
// Buffers drawer pixel writes and issues them one at a time
// as single-beat AXI4 writes.
module gfx_pixel_axi_writer
    import gfx_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixel_write_enable,
    input  logic [ADDR_WIDTH-1:0] pixel_addr,
    input  logic [31:0]           pixel_data,
    output logic                  pixel_ready,
    input  logic                  error_clear,
    gfx_pixel_axi_writer_if.master m00_axi,
    output logic                  m00_axi_error,
    output logic                  idle,
    output logic [31:0]           pixels_written
);
    localparam int PW = ADDR_WIDTH + 32;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'(3);

    wr_state_e             state_q;
    wr_state_e             state_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic [PW-1:0]         head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [31:0]           head_data;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  error_q;
    logic [31:0]           count_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  b_okay;

    gfx_pixel_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pixel_write_enable),
        .push_data ({pixel_addr, pixel_data}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_addr, head_data} = head;

    assign aw_hs  = awvalid_q && m00_axi.awready;
    assign w_hs   = wvalid_q && m00_axi.wready;
    assign b_hs   = (state_q == WR_RESP) && m00_axi.bvalid;
    assign b_okay = (m00_axi.bresp == RESP_OKAY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= WR_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WR_XFER;
                end
            end
            // AW and W retire independently, in either order
            WR_XFER: begin
                if ((!awvalid_q || m00_axi.awready) &&
                    (!wvalid_q || m00_axi.wready))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m00_axi.bvalid) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            error_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            if (pop) begin
                awaddr_q  <= head_addr & ALIGN_MASK;
                wdata_q   <= head_data;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
            end else begin
                if (aw_hs) awvalid_q <= 1'b0;
                if (w_hs)  wvalid_q  <= 1'b0;
            end
            if (b_hs && b_okay) count_q <= count_q + 1'b1;
            // a fresh error wins over a coincident clear
            if (b_hs && !b_okay)  error_q <= 1'b1;
            else if (error_clear) error_q <= 1'b0;
        end
    end

    assign m00_axi.awaddr  = awaddr_q;
    assign m00_axi.awvalid = awvalid_q;
    assign m00_axi.awlen   = LEN_SINGLE;
    assign m00_axi.awsize  = SIZE_4B;
    assign m00_axi.awburst = BURST_INCR;
    assign m00_axi.wdata   = wdata_q;
    assign m00_axi.wstrb   = STRB_ALL;
    assign m00_axi.wlast   = wvalid_q;
    assign m00_axi.wvalid  = wvalid_q;
    assign m00_axi.bready  = (state_q == WR_RESP);

    assign pixel_ready    = !fifo_full;
    assign idle           = (state_q == WR_IDLE) && fifo_empty;
    assign m00_axi_error  = error_q;
    assign pixels_written = count_q;

endmodule

// File: tb/tb_gfx_pixel_axi_writer.sv
// Directed bench for gfx_pixel_axi_writer with a small
// scriptable AXI slave and handshake monitor.
module tb_gfx_pixel_axi_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pwe = 1'b0;
    logic        error_clear = 1'b0;
    logic [31:0] pixel_addr = '0;
    logic [31:0] pixel_data = '0;
    logic        pixel_ready;
    logic        m00_axi_error;
    logic        idle;
    logic [31:0] pixels_written;

    logic        aw_rdy = 1'b1;
    logic        w_rdy = 1'b1;
    int          b_cnt = 0;
    int          err_at = -1;
    logic        b_fire = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    int          idx = 0;
    logic        rdy;

    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    logic        pend_aw = 1'b0;
    logic        pend_w = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] pend_data = '0;

    gfx_pixel_axi_writer_if #(.ADDR_WIDTH(32)) axi ();

    assign axi.awready = aw_rdy;
    assign axi.wready  = w_rdy;
    assign axi.bvalid  = 1'b1;
    assign axi.bresp   = (b_cnt == err_at) ? 2'b10 : 2'b00;

    gfx_pixel_axi_writer #(
        .ADDR_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .pixel_write_enable (pwe),
        .pixel_addr         (pixel_addr),
        .pixel_data         (pixel_data),
        .pixel_ready        (pixel_ready),
        .error_clear        (error_clear),
        .m00_axi            (axi),
        .m00_axi_error      (m00_axi_error),
        .idle               (idle),
        .pixels_written     (pixels_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle && n < 200) begin
            tick();
            n++;
        end
        check(tag, idle, 1);
    endtask

    // Monitor: handshakes that fire on the next rising edge
    always @(negedge clk) begin
        b_fire = 1'b0;
        if (reset) begin
            pend_aw = 1'b0;
            pend_w  = 1'b0;
        end else begin
            if (pend_aw)
                check("aw_hold", {axi.awvalid, axi.awaddr},
                      {1'b1, pend_addr});
            if (pend_w)
                check("w_hold", {axi.wvalid, axi.wdata},
                      {1'b1, pend_data});
            if (axi.awvalid && aw_rdy) aw_q.push_back(axi.awaddr);
            if (axi.wvalid && w_rdy) begin
                w_q.push_back(axi.wdata);
                check("w_beat", {axi.wstrb, axi.wlast}, {4'hF, 1'b1});
            end
            pend_aw   = axi.awvalid && !aw_rdy;
            pend_addr = axi.awaddr;
            pend_w    = axi.wvalid && !w_rdy;
            pend_data = axi.wdata;
            b_fire    = axi.bvalid && axi.bready;
        end
    end

    always @(posedge clk) begin
        if (b_fire) b_cnt <= b_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_awaddr", axi.awaddr, 0);
        check("rst_wdata", axi.wdata, 0);
        check("rst_idle", idle, 1);
        check("rst_ready", pixel_ready, 1);
        check("rst_count", pixels_written, 0);
        check("rst_err", m00_axi_error, 0);
        reset = 1'b0;
        tick();

        // single pixel, slave always ready
        pixel_addr = 32'h1000_0008;
        pixel_data = 32'hFF00_FF00;
        pwe = 1'b1;
        tick();
        pwe = 1'b0;
        check("lat_aw_low", axi.awvalid, 0);
        check("lat_idle", idle, 0);
        tick();
        check("t1_awvalid", axi.awvalid, 1);
        check("t1_wvalid", axi.wvalid, 1);
        check("t1_awaddr", axi.awaddr, 32'h1000_0008);
        check("t1_wdata", axi.wdata, 32'hFF00_FF00);
        check("t1_awlen", axi.awlen, 0);
        check("t1_awsize", axi.awsize, 3'b010);
        check("t1_awburst", axi.awburst, 2'b01);
        check("t1_bready0", axi.bready, 0);
        tick();
        check("t1_bready1", axi.bready, 1);
        check("t1_aw_drop", axi.awvalid, 0);
        tick();
        check("t1_count", pixels_written, 1);
        check("t1_idle", idle, 1);
        check("t1_aw_n", aw_q.size(), 1);
        check("t1_w_n", w_q.size(), 1);

        // three back-to-back pixels: one per 3 cycles
        for (int i = 0; i < 3; i++) begin
            pixel_addr = 32'h100 + 32'(i * 4);
            pixel_data = 32'(i);
            pwe = 1'b1;
            tick();
        end
        pwe = 1'b0;
        repeat (6) tick();
        check("tp_count_e8", pixels_written, 3);
        tick();
        check("tp_count_e9", pixels_written, 4);

        // error on second of three writes
        err_at = b_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            pixel_addr = 32'h200 + 32'(i * 4);
            pixel_data = 32'h50 + 32'(i);
            pwe = 1'b1;
            tick();
        end
        pwe = 1'b0;
        repeat (3) tick();
        check("err_before", m00_axi_error, 0);
        tick();
        check("err_set", m00_axi_error, 1);
        check("err_cnt_mid", pixels_written, 5);
        repeat (3) tick();
        check("err_cnt_end", pixels_written, 6);
        check("err_sticky", m00_axi_error, 1);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("err_cleared", m00_axi_error, 0);

        // clear coincides with a fresh error response
        err_at = b_cnt;
        error_clear = 1'b1;
        pixel_addr = 32'h300;
        pixel_data = 32'h77;
        pwe = 1'b1;
        tick();
        pwe = 1'b0;
        repeat (3) tick();
        check("err_coinc", m00_axi_error, 1);
        check("err_coinc_cnt", pixels_written, 6);
        error_clear = 1'b0;
        err_at = -1;
        tick();
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        check("err_clr2", m00_axi_error, 0);

        // unaligned address
        pixel_addr = 32'h2000_0003;
        pixel_data = 32'h1234_5678;
        pwe = 1'b1;
        tick();
        pwe = 1'b0;
        tick();
        check("align_awaddr", axi.awaddr, 32'h2000_0000);
        wait_idle("align_idle");
        check("align_count", pixels_written, 7);

        // six pixels against a stalled AW channel
        aw_q.delete();
        w_q.delete();
        aw_rdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            pwe = (idx < 6);
            pixel_addr = 32'h3000_0000 + 32'(idx * 4);
            pixel_data = 32'hA0 + 32'(idx);
            rdy = pixel_ready;
            tick();
            if (pwe && rdy) idx++;
        end
        check("burst_accepted", idx, 5);
        check("burst_ready_low", pixel_ready, 0);
        check("burst_aw_held", axi.awvalid, 1);
        aw_rdy = 1'b1;
        for (int c = 0; c < 50 && idx < 6; c++) begin
            pwe = 1'b1;
            pixel_addr = 32'h3000_0000 + 32'(idx * 4);
            pixel_data = 32'hA0 + 32'(idx);
            rdy = pixel_ready;
            tick();
            if (rdy) idx++;
        end
        pwe = 1'b0;
        check("burst_all_in", idx, 6);
        wait_idle("burst_idle");
        check("burst_count", pixels_written, 13);
        check("burst_aw_n", aw_q.size(), 6);
        check("burst_w_n", w_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("burst_aw",
                  (i < aw_q.size()) ? aw_q[i] : 32'hDEAD_BEEF,
                  32'h3000_0000 + 32'(i * 4));
            check("burst_w",
                  (i < w_q.size()) ? w_q[i] : 32'hDEAD_BEEF,
                  32'hA0 + 32'(i));
        end

        // W before AW, then AW before W
        aw_q.delete();
        w_q.delete();
        aw_rdy = 1'b0;
        w_rdy = 1'b0;
        pixel_addr = 32'h4000_0010;
        pixel_data = 32'h11;
        pwe = 1'b1;
        tick();
        pwe = 1'b0;
        tick();
        tick();
        w_rdy = 1'b1;
        tick();
        check("ord1_w_done", axi.wvalid, 0);
        check("ord1_aw_wait", axi.awvalid, 1);
        check("ord1_bready0", axi.bready, 0);
        tick();
        tick();
        aw_rdy = 1'b1;
        tick();
        check("ord1_aw_done", axi.awvalid, 0);
        check("ord1_bready1", axi.bready, 1);
        tick();
        aw_rdy = 1'b0;
        w_rdy = 1'b0;
        pixel_addr = 32'h4000_0020;
        pixel_data = 32'h22;
        pwe = 1'b1;
        tick();
        pwe = 1'b0;
        tick();
        aw_rdy = 1'b1;
        tick();
        check("ord2_aw_done", axi.awvalid, 0);
        check("ord2_w_wait", axi.wvalid, 1);
        check("ord2_bready0", axi.bready, 0);
        aw_rdy = 1'b0;
        tick();
        tick();
        w_rdy = 1'b1;
        tick();
        check("ord2_w_done", axi.wvalid, 0);
        check("ord2_bready1", axi.bready, 1);
        wait_idle("ord_idle");
        check("ord_aw_n", aw_q.size(), 2);
        check("ord_w_n", w_q.size(), 2);
        check("ord_aw1", (aw_q.size() > 1) ? aw_q[1] : 32'h0,
              32'h4000_0020);
        check("ord_w0", (w_q.size() > 0) ? w_q[0] : 32'h0, 32'h11);
        check("ord_count", pixels_written, 15);

        // reset in the middle of a stalled transfer
        aw_rdy = 1'b0;
        w_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pixel_addr = 32'h5000_0000 + 32'(i * 4);
            pixel_data = 32'hC0 + 32'(i);
            pwe = 1'b1;
            tick();
        end
        pwe = 1'b0;
        check("mid_awvalid", axi.awvalid, 1);
        check("mid_idle", idle, 0);
        reset = 1'b1;
        #1;
        check("mrst_awvalid", axi.awvalid, 0);
        check("mrst_wvalid", axi.wvalid, 0);
        check("mrst_idle", idle, 1);
        check("mrst_ready", pixel_ready, 1);
        check("mrst_count", pixels_written, 0);
        tick();
        check("mrst_hold_idle", idle, 1);
        reset = 1'b0;
        aw_rdy = 1'b1;
        w_rdy = 1'b1;
        tick();
        check("post_idle", idle, 1);
        aw_q.delete();
        w_q.delete();
        pixel_addr = 32'h6000_0004;
        pixel_data = 32'hBEEF;
        pwe = 1'b1;
        tick();
        pwe = 1'b0;
        wait_idle("post_wait");
        check("post_count", pixels_written, 1);
        check("post_aw_n", aw_q.size(), 1);
        check("post_aw", (aw_q.size() > 0) ? aw_q[0] : 32'h0,
              32'h6000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
